// File: rtl/tas_pkg.sv
// rtl/tas_pkg.sv - shared types and constants for the TAS serial transmit path
package tas_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;
  localparam int BYTE_W  = 8;
  localparam int MIN_GAP = 2;
endpackage

// File: rtl/tas_serial_tx_if.sv
// rtl/tas_serial_tx_if.sv - parallel byte input and serial link output bundle
interface tas_serial_tx_if #(parameter int DEPTH = 4);
  import tas_pkg::*;
  logic [BYTE_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   serial_data;
  logic                   data_ena;
  logic                   tx_done;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (output in_data, in_valid,
                  input  in_ready, serial_data, data_ena, tx_done, busy, fifo_count);
  modport slave  (input  in_data, in_valid,
                  output in_ready, serial_data, data_ena, tx_done, busy, fifo_count);
endinterface

// File: rtl/tas_tx_fifo.sv
// rtl/tas_tx_fifo.sv - byte FIFO; pushes when full and pops when empty are dropped
module tas_tx_fifo
  import tas_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tas_serial_tx.sv
// rtl/tas_serial_tx.sv - TAS link transmitter: FIFO-buffered bytes sent LSB-first
// as 8-cycle data_ena bursts separated by a fixed idle gap.
module tas_serial_tx
  import tas_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = MIN_GAP
) (
  input logic            clk_50,
  input logic            reset,
  tas_serial_tx_if.slave bus
);
  localparam int GAP_W = $clog2(GAP + 1);

  tx_state_t              state;
  logic [BYTE_W-1:0]      shift_reg;
  logic [2:0]             bit_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   avail;
  logic                   sd_q;
  logic                   de_q;
  logic                   done_q;
  logic                   fifo_pop;
  logic [BYTE_W-1:0]      fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_cnt;

  tas_tx_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk   (clk_50),
    .rst   (reset),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // avail delays the idle start by one edge so a fresh byte is written before it is read.
  always_comb begin
    fifo_pop = 1'b0;
    if (state == TX_IDLE && avail && !fifo_empty) fifo_pop = 1'b1;
    if (state == TX_GAP && gap_cnt == GAP_W'(GAP) && !fifo_empty) fifo_pop = 1'b1;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      avail     <= 1'b0;
      sd_q      <= 1'b0;
      de_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      avail  <= ~fifo_empty;
      done_q <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (fifo_pop) begin
            state     <= TX_SHIFT;
            shift_reg <= fifo_dout >> 1;
            sd_q      <= fifo_dout[0];
            de_q      <= 1'b1;
            bit_cnt   <= '0;
          end
        end
        TX_SHIFT: begin
          if (bit_cnt == 3'd7) begin
            state   <= TX_GAP;
            de_q    <= 1'b0;
            sd_q    <= 1'b0;
            done_q  <= 1'b1;
            gap_cnt <= GAP_W'(1);
          end else begin
            sd_q      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 3'd1;
          end
        end
        TX_GAP: begin
          if (gap_cnt == GAP_W'(GAP)) begin
            if (fifo_pop) begin
              state     <= TX_SHIFT;
              shift_reg <= fifo_dout >> 1;
              sd_q      <= fifo_dout[0];
              de_q      <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = ~fifo_full;
  assign bus.fifo_count  = fifo_cnt;
  assign bus.busy        = (state != TX_IDLE) | ~fifo_empty;
  assign bus.serial_data = sd_q;
  assign bus.data_ena    = de_q;
  assign bus.tx_done     = done_q;
endmodule

// File: tb/tb_tas_serial_tx.sv
// tb/tb_tas_serial_tx.sv - scoreboard bench for tas_serial_tx (GAP=2 and GAP=5 instances)
module tb_tas_serial_tx;
  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  always #10 clk_50 = ~clk_50;

  tas_serial_tx_if #(.DEPTH(4)) a ();
  tas_serial_tx_if #(.DEPTH(4)) b ();

  tas_serial_tx #(.DEPTH(4), .GAP(2)) dut  (.clk_50(clk_50), .reset(reset), .bus(a));
  tas_serial_tx #(.DEPTH(4), .GAP(5)) dut5 (.clk_50(clk_50), .reset(reset), .bus(b));

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] rx_byte [$];
  int         rx_len [$];
  int         rx_gap [$];
  logic [7:0] rxb_byte [$];
  int         rxb_gap [$];

  int sd_viol = 0, done_viol = 0, ready_viol = 0, max_count = 0;
  bit saw_full_block = 0;

  // Receiver model for the GAP=2 instance: reassembles bursts and measures gaps.
  logic prev_de = 0;
  int len = 0, low_cnt = 1000, cur_gap = 0;
  logic [7:0] cur = '0;
  always @(negedge clk_50) begin
    if (reset) begin
      prev_de = 0; len = 0; low_cnt = 1000;
    end else begin
      if (a.tx_done !== (prev_de && !a.data_ena)) done_viol++;
      if (!a.data_ena && a.serial_data !== 1'b0) sd_viol++;
      if (a.in_ready !== (a.fifo_count < 4)) ready_viol++;
      if (int'(a.fifo_count) > max_count) max_count = int'(a.fifo_count);
      if (a.fifo_count == 4 && a.in_ready === 1'b0) saw_full_block = 1;
      if (a.data_ena) begin
        if (!prev_de) begin len = 0; cur_gap = low_cnt; end
        cur = {a.serial_data, cur[7:1]};
        len++;
        low_cnt = 0;
      end else begin
        if (prev_de) begin
          rx_byte.push_back(cur); rx_len.push_back(len); rx_gap.push_back(cur_gap);
        end
        low_cnt++;
      end
      prev_de = a.data_ena;
    end
  end

  logic prev_de_b = 0;
  int low_b = 1000, gap_b = 0;
  logic [7:0] cur_b = '0;
  always @(negedge clk_50) begin
    if (reset) begin
      prev_de_b = 0; low_b = 1000;
    end else begin
      if (b.data_ena) begin
        if (!prev_de_b) gap_b = low_b;
        cur_b = {b.serial_data, cur_b[7:1]};
        low_b = 0;
      end else begin
        if (prev_de_b) begin rxb_byte.push_back(cur_b); rxb_gap.push_back(gap_b); end
        low_b++;
      end
      prev_de_b = b.data_ena;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    int cnt = 0;
    @(negedge clk_50);
    a.in_data = d; a.in_valid = 1'b1;
    while (!a.in_ready && cnt < 200) begin @(negedge clk_50); cnt++; end
    total++;
    if (!a.in_ready) $display("FAIL push_wait: in_ready=%b required 1 within 200 cycles", a.in_ready);
    else passed++;
    @(posedge clk_50);
    exp_q.push_back(d);
  endtask

  task automatic wait_rx(input int n, input string name);
    int cnt = 0;
    while (rx_byte.size() < n && cnt < 600) begin @(negedge clk_50); cnt++; end
    total++;
    if (rx_byte.size() < n) $display("FAIL %s_timeout: got %0d bursts required %0d", name, rx_byte.size(), n);
    else passed++;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (a.busy && cnt < 600) begin @(negedge clk_50); cnt++; end
    repeat (4) @(negedge clk_50);
  endtask

  task automatic get_rx(output logic [7:0] d, output int l, output int g, output logic [7:0] e);
    d = 8'hxx; l = -1; g = -1; e = 8'hzz;
    if (rx_byte.size() > 0) begin d = rx_byte.pop_front(); l = rx_len.pop_front(); g = rx_gap.pop_front(); end
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    a.in_valid = 0; a.in_data = '0; b.in_valid = 0; b.in_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
    total++; if ({a.serial_data, a.data_ena, a.tx_done, a.busy} !== 4'b0000)
      $display("FAIL reset_outputs: sd/de/done/busy=%b required 0000", {a.serial_data, a.data_ena, a.tx_done, a.busy});
    else passed++;
    total++; if (a.fifo_count !== 3'd0 || a.in_ready !== 1'b1)
      $display("FAIL reset_fifo: count=%0d ready=%b required 0 1", a.fifo_count, a.in_ready);
    else passed++;
  endtask

  task automatic test_single();
    logic [7:0] d, e; int l, g, cnt;
    push_byte(8'hA5);
    @(negedge clk_50); a.in_valid = 1'b0;
    total++; if (a.data_ena !== 1'b0 || a.fifo_count !== 3'd1)
      $display("FAIL lat_edge1: de=%b count=%0d required 0 1", a.data_ena, a.fifo_count);
    else passed++;
    @(negedge clk_50);
    total++; if (a.data_ena !== 1'b0) $display("FAIL lat_edge2: de=%b required 0", a.data_ena); else passed++;
    @(negedge clk_50);
    total++; if (a.data_ena !== 1'b1 || a.serial_data !== 1'b1)
      $display("FAIL lat_first_bit: de=%b sd=%b required 1 1", a.data_ena, a.serial_data);
    else passed++;
    cnt = 0;
    while (!a.tx_done && cnt < 50) begin @(negedge clk_50); cnt++; end
    total++; if (a.tx_done !== 1'b1 || a.busy !== 1'b1)
      $display("FAIL done_pulse: done=%b busy=%b required 1 1", a.tx_done, a.busy);
    else passed++;
    @(negedge clk_50);
    total++; if (a.busy !== 1'b1 || a.tx_done !== 1'b0)
      $display("FAIL gap_busy: busy=%b done=%b required 1 0", a.busy, a.tx_done);
    else passed++;
    @(negedge clk_50);
    total++; if (a.busy !== 1'b0) $display("FAIL busy_drop: busy=%b required 0", a.busy); else passed++;
    wait_rx(1, "single");
    get_rx(d, l, g, e);
    total++; if (d !== 8'hA5 || l != 8)
      $display("FAIL single_byte: got %h len %0d required a5 len 8", d, l);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e; int l, g;
    logic [7:0] pat [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    foreach (pat[i]) push_byte(pat[i]);
    @(negedge clk_50); a.in_valid = 1'b0;
    wait_rx(4, "b2b");
    for (int i = 0; i < 4; i++) begin
      get_rx(d, l, g, e);
      total++; if (d !== e || l != 8)
        $display("FAIL b2b_byte%0d: got %h len %0d required %h len 8", i, d, l, e);
      else passed++;
      if (i > 0) begin
        total++; if (g != 2) $display("FAIL b2b_gap%0d: got %0d low cycles required 2", i, g);
        else passed++;
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] d, e; int l, g;
    max_count = 0; saw_full_block = 0;
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i * 37));
    @(negedge clk_50); a.in_valid = 1'b0;
    wait_rx(6, "full");
    total++; if (max_count != 4 || !saw_full_block)
      $display("FAIL full_count: max=%0d blocked=%0d required 4 1", max_count, saw_full_block);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      get_rx(d, l, g, e);
      total++; if (d !== e || l != 8)
        $display("FAIL full_byte%0d: got %h len %0d required %h len 8", i, d, l, e);
      else passed++;
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] d, e; int l, g;
    wait_idle();
    push_byte(8'h11);
    push_byte(8'h22);
    #1;
    total++; if (a.fifo_count !== 3'd2) $display("FAIL se_count_pre: got %0d required 2", a.fifo_count);
    else passed++;
    push_byte(8'h33);
    #1;
    total++; if (a.fifo_count !== 3'd2 || a.data_ena !== 1'b1)
      $display("FAIL se_count_pop: count=%0d de=%b required 2 1", a.fifo_count, a.data_ena);
    else passed++;
    @(negedge clk_50); a.in_valid = 1'b0;
    wait_rx(3, "same_edge");
    for (int i = 0; i < 3; i++) begin
      get_rx(d, l, g, e);
      total++; if (d !== e) $display("FAIL se_order%0d: got %h required %h", i, d, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_byte();
    int cnt = 0, de_seen = 0;
    wait_idle();
    push_byte(8'h3C); push_byte(8'hAA); push_byte(8'h55);
    @(negedge clk_50); a.in_valid = 1'b0;
    while (!a.data_ena && cnt < 20) begin @(negedge clk_50); cnt++; end
    repeat (4) @(negedge clk_50);
    total++; if (a.data_ena !== 1'b1 || a.serial_data !== 1'b1)
      $display("FAIL rst_bit4: de=%b sd=%b required 1 1", a.data_ena, a.serial_data);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (a.data_ena !== 1'b0 || a.serial_data !== 1'b0 || a.fifo_count !== 3'd0 || a.busy !== 1'b0)
      $display("FAIL rst_async: de=%b sd=%b count=%0d busy=%b required 0 0 0 0",
               a.data_ena, a.serial_data, a.fifo_count, a.busy);
    else passed++;
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
    exp_q.delete(); rx_byte.delete(); rx_len.delete(); rx_gap.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_50);
      if (a.data_ena) de_seen++;
    end
    total++; if (de_seen != 0 || a.fifo_count !== 3'd0 || a.in_ready !== 1'b1)
      $display("FAIL rst_no_resume: de_cycles=%0d count=%0d ready=%b required 0 0 1",
               de_seen, a.fifo_count, a.in_ready);
    else passed++;
  endtask

  task automatic test_gap5();
    int cnt = 0;
    logic [7:0] d0, d1;
    @(negedge clk_50); b.in_data = 8'h5A; b.in_valid = 1'b1;
    @(negedge clk_50); b.in_data = 8'hC3;
    @(negedge clk_50); b.in_valid = 1'b0;
    while (rxb_byte.size() < 2 && cnt < 100) begin @(negedge clk_50); cnt++; end
    total++;
    if (rxb_byte.size() < 2) $display("FAIL gap5_timeout: got %0d bursts required 2", rxb_byte.size());
    else begin
      passed++;
      d0 = rxb_byte.pop_front(); d1 = rxb_byte.pop_front();
      void'(rxb_gap.pop_front());
      total++; if (d0 !== 8'h5A || d1 !== 8'hC3)
        $display("FAIL gap5_bytes: got %h %h required 5a c3", d0, d1);
      else passed++;
      total++; if (rxb_gap[0] != 5) $display("FAIL gap5_gap: got %0d low cycles required 5", rxb_gap[0]);
      else passed++;
    end
  endtask

  task automatic test_invariants();
    total++; if (sd_viol != 0) $display("FAIL sd_low_when_idle: violations=%0d required 0", sd_viol); else passed++;
    total++; if (done_viol != 0) $display("FAIL tx_done_timing: violations=%0d required 0", done_viol); else passed++;
    total++; if (ready_viol != 0) $display("FAIL in_ready_rule: violations=%0d required 0", ready_viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_same_edge();
    test_reset_mid_byte();
    test_gap5();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
